// File: rtl/fpu_add_iter_if.sv
// Handshake and operand/result bus for the iterative FP adder.
interface fpu_add_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                     in_valid;
    logic                     in_ready;
    logic [EXP_W+MAN_W:0]     opa;
    logic [EXP_W+MAN_W:0]     opb;
    logic                     fsub;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+MAN_W+3:0]   out;

    modport master (
        output in_valid, opa, opb, fsub, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, opa, opb, fsub, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fpu_add_iter.sv
// Iterative floating-point add/sub: aligns at accept, normalizes one bit per
// cycle, and emits the unrounded result with guard/round/sticky bits.
module fpu_add_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit FTZ   = 1'b0
) (
    input logic           clk,
    input logic           rst,
    fpu_add_iter_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int FW   = EXP_W + MAN_W;
    localparam int RW   = 2 * MAN_W + 4;
    localparam int XW   = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t                  state;
    logic [RW-1:0]           r;
    logic signed [XW-1:0]    e;
    logic                    rs;
    logic                    spec;
    logic [W+2:0]            spec_out;

    logic                    sa, sb, eff_sub, swap, new_sign;
    logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [FW-1:0]           mag_a, mag_b, mag_l, mag_s;
    logic [EXP_W-1:0]        el, es, d;
    logic [RW-1:0]           ml, ms, sum;
    logic                    skip, pre_spec;
    logic [W+2:0]            pre_out;

    always_comb begin
        sa       = bus.opa[W-1];
        sb       = bus.opb[W-1];
        mag_a    = bus.opa[FW-1:0];
        mag_b    = bus.opb[FW-1:0];
        a_nan    = (&mag_a[FW-1:MAN_W]) && (|mag_a[MAN_W-1:0]);
        b_nan    = (&mag_b[FW-1:MAN_W]) && (|mag_b[MAN_W-1:0]);
        a_inf    = (&mag_a[FW-1:MAN_W]) && !(|mag_a[MAN_W-1:0]);
        b_inf    = (&mag_b[FW-1:MAN_W]) && !(|mag_b[MAN_W-1:0]);
        a_zero   = (mag_a == '0);
        b_zero   = (mag_b == '0);
        // ties keep A as the larger operand so equal-inf pairs take A's sign
        swap     = (mag_b > mag_a);
        mag_l    = swap ? mag_b : mag_a;
        mag_s    = swap ? mag_a : mag_b;
        eff_sub  = sa ^ sb ^ bus.fsub;
        new_sign = swap ? (sb ^ bus.fsub) : sa;
        el       = (mag_l[FW-1:MAN_W] == '0) ? EXP_W'(1) : mag_l[FW-1:MAN_W];
        es       = (mag_s[FW-1:MAN_W] == '0) ? EXP_W'(1) : mag_s[FW-1:MAN_W];
        d        = el - es;
        skip     = (d > EXP_W'(MAN_W + 2));
        ml       = {1'b0, |mag_l[FW-1:MAN_W], mag_l[MAN_W-1:0], {(MAN_W+2){1'b0}}};
        ms       = {1'b0, |mag_s[FW-1:MAN_W], mag_s[MAN_W-1:0], {(MAN_W+2){1'b0}}} >> d;
        sum      = eff_sub ? (ml - ms) : (ml + ms);

        pre_spec = 1'b1;
        pre_out  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            pre_out = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W+2){1'b0}}};
        else if (a_inf || b_inf)
            pre_out = {new_sign, mag_l, 3'b000};
        else if ((mag_a == mag_b) && eff_sub)
            pre_out = '0;
        else if (a_zero || b_zero)
            pre_out = {new_sign, mag_l, 3'b000};
        else if (skip)
            pre_out = {new_sign, mag_l, 3'b001};
        else
            pre_spec = 1'b0;
    end

    logic                 oflow, uflow;
    logic [XW-1:0]        sh;
    logic [RW-1:0]        m, lost_mask;

    always_comb begin
        oflow     = (int'(e) >= EMAX);
        uflow     = (int'(e) <= 0);
        sh        = XW'(1) - e;
        m         = r;
        lost_mask = '0;
        // subnormal result: denormalize so the exponent field reads as zero
        if (uflow) begin
            if (sh >= XW'(RW)) begin
                m         = '0;
                lost_mask = '1;
            end else begin
                m         = r >> sh;
                lost_mask = ~({RW{1'b1}} << sh);
            end
        end

        if (spec)
            bus.out = spec_out;
        else if (oflow)
            bus.out = {rs, {EXP_W{1'b1}}, {(MAN_W+3){1'b0}}};
        else if (uflow && FTZ)
            bus.out = {rs, {(W+2){1'b0}}};
        else
            bus.out = {rs, uflow ? {EXP_W{1'b0}} : e[EXP_W-1:0],
                       m[RW-2 -: MAN_W], m[RW-2-MAN_W], m[RW-3-MAN_W],
                       (|m[MAN_W:0]) | (|(r & lost_mask))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            r             <= '0;
            e             <= '0;
            rs            <= 1'b0;
            spec          <= 1'b0;
            spec_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r            <= sum;
                        e            <= {2'b00, el} + XW'(1);
                        rs           <= new_sign;
                        spec         <= pre_spec;
                        spec_out     <= pre_out;
                        state        <= NORM;
                        bus.in_ready <= 1'b0;
                    end
                end
                NORM: begin
                    if (spec || r[RW-1]) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end else begin
                        r <= r << 1;
                        e <= e - XW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_add_iter.sv
// Directed bench for fpu_add_iter; two instances share stimulus, FTZ off/on.
module tb_fpu_add_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_add_iter_if #(.EXP_W(8), .MAN_W(23)) if0 ();
    fpu_add_iter_if #(.EXP_W(8), .MAN_W(23)) if1 ();

    fpu_add_iter #(.EXP_W(8), .MAN_W(23), .FTZ(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    fpu_add_iter #(.EXP_W(8), .MAN_W(23), .FTZ(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int errors = 0;

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic ordy);
        if0.in_valid = v;  if0.opa = a;  if0.opb = b;  if0.fsub = s;  if0.out_ready = ordy;
        if1.in_valid = v;  if1.opa = a;  if1.opb = b;  if1.fsub = s;  if1.out_ready = ordy;
    endtask

    // Issues one operation, scrambles inputs after accept, waits for both results.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [34:0] r0, output logic [34:0] r1,
                         output int lat, output bit busy);
        busy = 1'b0;
        lat  = -1;
        r0   = '0;
        r1   = '0;
        drive(1'b1, a, b, s, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, ~a, ~b, ~s, 1'b0);
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            if (if0.in_ready || if1.in_ready) busy = 1'b1;
            @(posedge clk); #1;
            if (if0.out_valid && if1.out_valid) begin
                lat = k;
                r0  = if0.out;
                r1  = if1.out;
                if (if0.in_ready || if1.in_ready) busy = 1'b1;
            end
        end
        if (lat > 0) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            @(posedge clk); #1;
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end else begin
            checks++; errors++;
            $display("FAIL timeout a=%h b=%h: no out_valid within 60 cycles", a, b);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b/%b want=1", if0.in_ready, if1.in_ready);
        end
        checks++;
        if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b/%b want=0", if0.out_valid, if1.out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [34:0] vr [8];
        int          vl [8];
        logic [34:0] r0, r1;
        int          lat;
        bit          busy;
        va = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF};
        vb = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'h33800000,
               32'h33000000, 32'h32800000, 32'h30800000, 32'h7F7FFFFF};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vr = '{{32'h40000000, 3'b000}, {32'hC0000000, 3'b000}, {32'hBF800000, 3'b000},
               {32'h3F800000, 3'b100}, {32'h3F800000, 3'b010}, {32'h3F800000, 3'b001},
               {32'h3F800000, 3'b001}, {32'h7F800000, 3'b000}};
        vl = '{1, 1, 3, 2, 2, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vs[i], r0, r1, lat, busy);
            checks++;
            if (r0 !== vr[i]) begin
                errors++; $display("FAIL arith%0d out got=%h want=%h", i, r0, vr[i]);
            end
            checks++;
            if (r1 !== vr[i]) begin
                errors++; $display("FAIL arith%0d ftz_out got=%h want=%h", i, r1, vr[i]);
            end
            checks++;
            if (lat != vl[i]) begin
                errors++; $display("FAIL arith%0d latency got=%0d want=%0d", i, lat, vl[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic        vs [7];
        logic [34:0] vr [7];
        logic [34:0] r0, r1;
        int          lat;
        bit          busy;
        va = '{32'h7F800000, 32'hFF800001, 32'h7F800000, 32'h3F800000,
               32'h3F800000, 32'h00000000, 32'h3F800000};
        vb = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
               32'h3F800000, 32'h3F800000, 32'h80000000};
        vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vr = '{{32'h7FC00000, 3'b000}, {32'h7FC00000, 3'b000}, {32'h7F800000, 3'b000},
               {32'hFF800000, 3'b000}, {32'h00000000, 3'b000}, {32'hBF800000, 3'b000},
               {32'h3F800000, 3'b000}};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vs[i], r0, r1, lat, busy);
            checks++;
            if (r0 !== vr[i]) begin
                errors++; $display("FAIL special%0d out got=%h want=%h", i, r0, vr[i]);
            end
            checks++;
            if (lat != 1) begin
                errors++; $display("FAIL special%0d latency got=%0d want=1", i, lat);
            end
        end
    endtask

    task automatic test_cancel();
        logic [34:0] r0, r1;
        int          lat;
        bit          busy;
        do_op(32'h3F800000, 32'h3F7FFFFF, 1'b1, r0, r1, lat, busy);
        checks++;
        if (r0 !== {32'h33800000, 3'b000}) begin
            errors++; $display("FAIL cancel out got=%h want=%h", r0, {32'h33800000, 3'b000});
        end
        checks++;
        if (lat != 26) begin
            errors++; $display("FAIL cancel latency got=%0d want=26", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cancel in_ready seen high while busy got=%b want=0", busy);
        end
    endtask

    task automatic test_subnormal();
        logic [34:0] r0, r1;
        int          lat;
        bit          busy;
        do_op(32'h00800000, 32'h00400000, 1'b1, r0, r1, lat, busy);
        checks++;
        if (r0 !== {32'h00400000, 3'b000}) begin
            errors++; $display("FAIL subnorm out got=%h want=%h", r0, {32'h00400000, 3'b000});
        end
        checks++;
        if (r1 !== 35'h0) begin
            errors++; $display("FAIL subnorm_ftz out got=%h want=0", r1);
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL subnorm latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        got = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL bp_valid got=0 want=1");
        end
        drive(1'b1, 32'h40400000, 32'h40400000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (if0.out !== {32'h40000000, 3'b000} || if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d out=%h in_ready=%b out_valid=%b want out=%h 0 1",
                         k, if0.out, if0.in_ready, if0.out_valid, {32'h40000000, 3'b000});
            end
            @(posedge clk); #1;
        end
        drive(1'b1, 32'h40400000, 32'h40400000, 1'b0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1 0", if0.in_ready, if0.out_valid);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if0.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_accept in_ready got=%b want=1", if0.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        drive(1'b1, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid in_ready=%b out_valid=%b want 1 0", if0.in_ready, if0.out_valid);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid || if1.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_abort out_valid cycles got=%0d want=0", seen);
        end
        checks++;
        if (if0.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_idle in_ready got=%b want=1", if0.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_cancel();
        test_subnormal();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
